store_narrow_unit: RTL and testbench
====================================

// Module: store_narrow_unit
// PURPOSE
//  Data-memory store path of the MIPS CPU; the narrowing counterpart of the load-side sign extender.
//  Truncates a 32-bit register value to byte/halfword/word and places it in the addressed lane.
//  Sub-word stores (SB/SH) run read-modify-write against the word-wide data memory, which has no byte enables.
//  Sits between EX/MEM store issue and the data-memory port; the pipeline stalls while busy.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width (mem_addr has the same width, low 2 bits forced to 0)
//  DATA_WIDTH  32  register/memory word width; only 32 is supported
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   store request present
//  req_ready   out  1   high only in IDLE; request accepted when req_valid & req_ready
//  req_addr    in   32  byte address
//  req_data    in   32  rt register value
//  req_size    in   2   00=byte, 01=half, 10=word, 11=illegal
//  done        out  1   one-cycle completion pulse
//  misaligned  out  1   valid with done; 1 = request rejected, memory untouched
//  mem_addr    out  32  word-aligned address {req_addr[31:2],2'b00}
//  mem_rd      out  1   read strobe, held until mem_rvalid
//  mem_rdata   in   32  read data
//  mem_rvalid  in   1   read data valid
//  mem_wr      out  1   write strobe, held until mem_wack
//  mem_wdata   out  32  merged write word
//  mem_wack    in   1   write accepted
// BEHAVIOUR
//  Reset: state=IDLE; done, misaligned, mem_rd, mem_wr = 0; mem_addr, mem_wdata = 0; req_ready = 1.
//  FSM states: IDLE, READ, WRITE, DONE, ERR.
//  IDLE: on accept, latch addr/data/size/offset; next state is
//   ERR if size=11, half with addr[0]=1, or word with addr[1:0]!=0;
//   WRITE if word (mem_wdata = req_data, no read);
//   READ otherwise.
//  READ: mem_rd=1, mem_addr stable. When mem_rvalid: mem_wdata <= merge(mem_rdata); next state WRITE.
//  WRITE: mem_wr=1, addr/wdata stable. When mem_wack: next state DONE.
//  DONE: done=1, misaligned=0 for one cycle; next state IDLE.
//  ERR: done=1, misaligned=1 for one cycle; next state IDLE. mem_rd/mem_wr are never asserted.
//  Truncation: byte uses req_data[7:0], half uses req_data[15:0]; upper bits discarded unconditionally.
//  Lane map (big-endian):
//   byte offset 0..3 -> bits [31:24],[23:16],[15:8],[7:0];
//   half offset 0 -> [31:16], offset 2 -> [15:0].
//   Unaddressed lanes keep mem_rdata.
//  Latency from the accept edge:
//   SW    -> mem_wr on cycle +1; done the cycle after mem_wack;
//   SB/SH -> mem_rd on cycle +1;
//   error -> done on cycle +1.
//  req_ready=0 in READ/WRITE/DONE/ERR; req_valid is ignored there, including in the done cycle.
//  mem_rvalid outside READ and mem_wack outside WRITE are ignored.
//  Reset mid-operation: on the reset edge the FSM goes to IDLE and mem_rd/mem_wr drop.
//   No done pulse; the partial read is discarded and memory is left unmodified.
// STRUCTURE
//  Shared package/header mips_mem_pkg:
//   size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL;
//   FSM state encodings;
//   misalignment predicate.
//  One combinational sub-module, store_lane_merge:
//   inputs (old_word, new_data, size, offset[1:0]) -> merged word.
//   Reused by a future store buffer.
// TESTING
//  1. SW 0x100, data 0xDEADBEEF
//     -> no mem_rd; mem_wr, mem_addr 0x100, wdata 0xDEADBEEF; done 1 cycle after wack.
//  2. SB 0x103, data 0x123456AB, rdata 0x11223344
//     -> wdata 0x112233AB;
//     SB 0x100, same data -> wdata 0xAB223344.
//  3. SH 0x202, data 0xFFFF8000, rdata 0xAABBCCDD -> wdata 0xAABB8000;
//     SH 0x200 -> 0x8000CCDD.
//  4. SH 0x201, SW 0x102, size 11
//     -> done & misaligned on cycle +1; mem_rd/mem_wr stay 0.
//  5. SB with mem_rvalid held low 3 cycles, reset asserted in cycle 2
//     -> mem_rd 0 after the edge, req_ready 1, no done, no mem_wr.
//  6. req_valid held high across done, stray mem_wack in IDLE
//     -> second request accepted only in IDLE; stray ack has no effect.

Source files
------------

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the data-memory store path: access size codes,
// store FSM state encodings and the alignment rule for sub-word stores.
package store_narrow_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // A store is rejected when its size code is illegal or the address is not
    // naturally aligned for that size; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            SIZE_ILL:  bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the truncated store data into its big-endian
// lane of an existing memory word, leaving every other lane untouched.
module store_lane_merge
    import store_narrow_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    // Start from the old word and overwrite only the addressed lane.
    always_comb begin
        merged = old_word;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    merged[31:24] = new_data[7:0];
                    2'd1:    merged[23:16] = new_data[7:0];
                    2'd2:    merged[15:8]  = new_data[7:0];
                    default: merged[7:0]   = new_data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) begin
                    merged[15:0] = new_data[15:0];
                end else begin
                    merged[31:16] = new_data[15:0];
                end
            end
            SIZE_WORD: merged = new_data;
            default:   merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store path between EX/MEM and the word-wide data memory. Word stores write
// directly; byte and halfword stores read the word, merge, then write it back.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic                  done,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wack
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            offset_q, offset_d;
    logic [1:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] merged;

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .size     (size_q),
        .offset   (offset_q),
        .merged   (merged)
    );

    // Next-state and datapath updates; a reset mid-operation simply abandons
    // the partial read because nothing reaches memory before WRITE.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        offset_d = offset_q;
        size_d   = size_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    offset_d = req_addr[1:0];
                    size_d   = req_size;
                    data_d   = req_data;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (req_size == SIZE_WORD) begin
                        wdata_d = req_data;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_rvalid) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_wack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            offset_q <= 2'b00;
            size_q   <= 2'b00;
            data_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            offset_q <= offset_d;
            size_q   <= size_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_rd     = (state_q == ST_READ);
    assign mem_wr     = (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign misaligned = (state_q == ST_ERR);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: byte-addressed big-endian reference memory,
// reactive memory responder and a done-driven scoreboard monitor.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    typedef struct {
        logic        mis;
        logic        is_word;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    logic [31:0] wmem[int unsigned];
    logic [7:0]  bmem[int unsigned];
    bit          hold_rvalid = 1'b0;
    bit          force_wack = 1'b0;
    bit          rd_seen = 1'b0;
    bit          wr_seen = 1'b0;
    bit          expect_done_next = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] last_wdata = '0;

    store_narrow_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .misaligned (misaligned),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] resp_word(input int unsigned a);
        if (wmem.exists(a)) return wmem[a];
        return init_word(a);
    endfunction

    function automatic logic [7:0] model_byte(input int unsigned a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = init_word(a & 32'hFFFF_FFFC);
        return w[8*(3-(a%4)) +: 8];
    endfunction

    function automatic logic [31:0] model_word(input int unsigned wa);
        return {model_byte(wa), model_byte(wa+1), model_byte(wa+2), model_byte(wa+3)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic preload(input int unsigned wa, input logic [31:0] w);
        wmem[wa] = w;
        for (int i = 0; i < 4; i++) bmem[wa+i] = w[8*(3-i) +: 8];
    endtask

    // Memory responder and scoreboard monitor, both evaluated away from the active edge.
    initial begin
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (expect_done_next) check_output("done_after_wack", {31'd0, done}, 32'd1);
            expect_done_next = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_rd) begin
                rd_seen = 1'b1;
                if (!hold_rvalid && $urandom_range(0, 2) != 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp_word(mem_addr);
                end
            end
            mem_wack = force_wack;
            if (mem_wr && $urandom_range(0, 2) != 0) begin
                mem_wack   = 1'b1;
                wr_seen    = 1'b1;
                wr_addr    = mem_addr;
                wr_data    = mem_wdata;
                last_wdata = mem_wdata;
                wmem[mem_addr] = mem_wdata;
                expect_done_next = 1'b1;
            end
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
                    if (!mon_e.mis) begin
                        check_output("write_seen", {31'd0, wr_seen}, 32'd1);
                        check_output("write_addr", wr_addr, mon_e.addr);
                        check_output("write_data", wr_data, mon_e.wdata);
                        check_output("read_seen", {31'd0, rd_seen}, {31'd0, !mon_e.is_word});
                    end else begin
                        check_output("err_write_seen", {31'd0, wr_seen}, 32'd0);
                        check_output("err_read_seen", {31'd0, rd_seen}, 32'd0);
                    end
                end
                rd_seen = 1'b0;
                wr_seen = 1'b0;
            end
        end
    end

    // Issue one store, record its expected outcome, check the first-cycle
    // behaviour after acceptance, then wait for its completion pulse.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s, input bit hold);
        exp_t        e;
        logic        mis;
        int unsigned wa;
        int          n;
        wa  = a & 32'hFFFF_FFFC;
        mis = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
        if (!mis) begin
            case (s)
                2'd0: bmem[a] = d[7:0];
                2'd1: begin bmem[a] = d[15:8]; bmem[a+1] = d[7:0]; end
                default: for (int i = 0; i < 4; i++) bmem[a+i] = d[8*(3-i) +: 8];
            endcase
        end
        e = '{mis, (s == 2'd2), wa, model_word(wa)};
        exp_q.push_back(e);
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        if (mis) begin
            check_output("err_done_lat", {31'd0, done}, 32'd1);
            check_output("err_mis_lat", {31'd0, misaligned}, 32'd1);
            check_output("err_no_rd", {31'd0, mem_rd}, 32'd0);
            check_output("err_no_wr", {31'd0, mem_wr}, 32'd0);
        end else if (s == 2'd2) begin
            check_output("sw_wr_lat", {31'd0, mem_wr}, 32'd1);
            check_output("sw_no_rd", {31'd0, mem_rd}, 32'd0);
            check_output("sw_addr", mem_addr, wa);
        end else begin
            check_output("sub_rd_lat", {31'd0, mem_rd}, 32'd1);
            check_output("sub_addr", mem_addr, wa);
        end
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("done_timeout", {31'd0, done}, 32'd1);
        check_output("ready_in_done", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by randomized stores.
    initial begin
        int d0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_mis", {31'd0, misaligned}, 32'd0);
        check_output("rst_rd", {31'd0, mem_rd}, 32'd0);
        check_output("rst_wr", {31'd0, mem_wr}, 32'd0);
        check_output("rst_addr", mem_addr, 32'd0);
        check_output("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        apply_stimulus(32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
        check_output("sw_wdata", last_wdata, 32'hDEADBEEF);

        preload(32'h100, 32'h11223344);
        apply_stimulus(32'h103, 32'h123456AB, 2'd0, 1'b0);
        check_output("sb3_wdata", last_wdata, 32'h112233AB);
        preload(32'h100, 32'h11223344);
        apply_stimulus(32'h100, 32'h123456AB, 2'd0, 1'b0);
        check_output("sb0_wdata", last_wdata, 32'hAB223344);

        preload(32'h200, 32'hAABBCCDD);
        apply_stimulus(32'h202, 32'hFFFF8000, 2'd1, 1'b0);
        check_output("sh2_wdata", last_wdata, 32'hAABB8000);
        preload(32'h200, 32'hAABBCCDD);
        apply_stimulus(32'h200, 32'hFFFF8000, 2'd1, 1'b0);
        check_output("sh0_wdata", last_wdata, 32'h8000CCDD);

        apply_stimulus(32'h201, 32'h0000BEEF, 2'd1, 1'b0);
        apply_stimulus(32'h102, 32'h01020304, 2'd2, 1'b0);
        apply_stimulus(32'h104, 32'h01020304, 2'd3, 1'b0);

        wait_idle();
        hold_rvalid = 1'b1;
        req_addr  = 32'h131;
        req_data  = 32'h000000EE;
        req_size  = 2'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("rst_mid_rd_start", {31'd0, mem_rd}, 32'd1);
        d0 = done_seen;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("rst_mid_rd", {31'd0, mem_rd}, 32'd0);
        check_output("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        reset = 1'b0;
        hold_rvalid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_output("rst_mid_no_done", done_seen, d0);
        check_output("rst_mid_no_write", {31'd0, wr_seen}, 32'd0);
        rd_seen = 1'b0;
        wr_seen = 1'b0;

        force_wack = 1'b1;
        @(posedge clk); #1;
        force_wack = 1'b0;
        check_output("stray_wack_wr", {31'd0, mem_wr}, 32'd0);
        check_output("stray_wack_done", {31'd0, done}, 32'd0);
        check_output("stray_wack_ready", {31'd0, req_ready}, 32'd1);

        apply_stimulus(32'h120, 32'hCAFEF00D, 2'd2, 1'b1);
        apply_stimulus(32'h125, 32'h00000077, 2'd0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            apply_stimulus(32'h100 + $urandom_range(0, 63), $urandom,
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
